// File: rtl/code_stim_gen.sv
// Command-driven En/Slt/CntReset sequencer for the dual event counter.
// Tracks the counter's Slt phase locally so Output1 increments land exactly.
module code_stim_gen #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         CmdValid,
  output logic         CmdReady,
  input  logic         CmdClear,
  input  logic [W-1:0] CmdCount0,
  input  logic [W-1:0] CmdCount1,
  input  logic [1:0]   CmdPad,
  input  logic         Hold,
  output logic         En,
  output logic         Slt,
  output logic         CntReset,
  output logic         Busy,
  output logic         Done,
  output logic [1:0]   Phase
);

  localparam int CW = W + 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN0  = 3'd2,
    RUN1  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] n0_rem, n1_rem, n0_nx, n1_nx;
  logic [CW-1:0] acc_n0, acc_n1, acc_s1;
  logic [1:0]    acc_p, phase_nx;
  logic          hold_q, pulse, run_nx;

  always_comb begin
    // Phase at RUN1 entry: a clear zeroes the counter's phase first.
    acc_p  = CmdClear ? 2'd0 : Phase;
    acc_s1 = (CmdCount1 == '0) ? '0
           : ({1'b0, CmdCount1, 2'b00} - {{(CW-2){1'b0}}, acc_p});
    acc_n0 = {3'b000, CmdCount0};
    acc_n1 = acc_s1 + {{(CW-2){1'b0}}, CmdPad};
    pulse  = ((state == RUN0) || (state == RUN1)) && !hold_q;

    state_nx = state;
    n0_nx    = n0_rem;
    n1_nx    = n1_rem;
    phase_nx = Phase;

    case (state)
      IDLE: begin
        if (CmdValid) begin
          n0_nx = acc_n0;
          n1_nx = acc_n1;
          if (CmdClear)             state_nx = CLEAR;
          else if (acc_n0 != '0)    state_nx = RUN0;
          else if (acc_n1 != '0)    state_nx = RUN1;
          else                      state_nx = DONE;
        end
      end
      CLEAR: begin
        phase_nx = 2'd0;
        if (n0_rem != '0)         state_nx = RUN0;
        else if (n1_rem != '0)    state_nx = RUN1;
        else                      state_nx = DONE;
      end
      RUN0: begin
        if (pulse) begin
          n0_nx = n0_rem - 1'b1;
          if (n0_rem == {{(CW-1){1'b0}}, 1'b1})
            state_nx = (n1_rem != '0) ? RUN1 : DONE;
        end
      end
      RUN1: begin
        if (pulse) begin
          n1_nx    = n1_rem - 1'b1;
          phase_nx = Phase + 2'd1;
          if (n1_rem == {{(CW-1){1'b0}}, 1'b1})
            state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    run_nx = (state_nx == RUN0) || (state_nx == RUN1);
  end

  // Drive outputs are registered from the next state, so En/Slt line up
  // with the state they belong to; Hold lands in hold_q on the same edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      n0_rem   <= '0;
      n1_rem   <= '0;
      Phase    <= 2'd0;
      hold_q   <= 1'b0;
      En       <= 1'b0;
      Slt      <= 1'b0;
      CntReset <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state    <= state_nx;
      n0_rem   <= n0_nx;
      n1_rem   <= n1_nx;
      Phase    <= phase_nx;
      hold_q   <= Hold;
      En       <= run_nx && !Hold;
      Slt      <= (state_nx == RUN1) && !Hold;
      CntReset <= (state_nx == CLEAR);
      Busy     <= run_nx || (state_nx == CLEAR);
      Done     <= (state_nx == DONE);
    end
  end

  assign CmdReady = (state == IDLE);

endmodule

// File: tb/tb_code_stim_gen.sv
// Directed bench for code_stim_gen with a behavioural model of the downstream
// dual event counter; all expected values are hand-computed constants.
module tb_code_stim_gen;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        CmdValid, CmdReady, CmdClear, Hold;
  logic [15:0] CmdCount0, CmdCount1;
  logic [1:0]  CmdPad;
  logic        En, Slt, CntReset, Busy, Done;
  logic [1:0]  Phase;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en0_tot = 0, slt_tot = 0, clr_tot = 0, busy_tot = 0, done_tot = 0;
  int out0 = 0, out1 = 0;
  logic [1:0] cph = 2'd0;

  code_stim_gen #(.W(16)) dut (
    .Clk(Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdClear(CmdClear), .CmdCount0(CmdCount0), .CmdCount1(CmdCount1),
    .CmdPad(CmdPad), .Hold(Hold), .En(En), .Slt(Slt), .CntReset(CntReset),
    .Busy(Busy), .Done(Done), .Phase(Phase)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (En && !Slt) en0_tot <= en0_tot + 1;
    if (En && Slt)  slt_tot <= slt_tot + 1;
    if (CntReset)   clr_tot <= clr_tot + 1;
    if (Busy)       busy_tot <= busy_tot + 1;
    if (Done)       done_tot <= done_tot + 1;
  end

  // Downstream counter: Output1 steps when its Slt phase wraps 3 -> 0.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out0 <= 0; out1 <= 0; cph <= 2'd0;
    end else if (CntReset) begin
      out0 <= 0; out1 <= 0; cph <= 2'd0;
    end else if (En && !Slt) begin
      out0 <= out0 + 1;
    end else if (En && Slt) begin
      cph <= cph + 2'd1;
      if (cph == 2'd3) out1 <= out1 + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic clr, input logic [15:0] n0, input logic [15:0] n1,
                      input logic [1:0] pad, output int e0);
    int n;
    n = 0;
    CmdClear = clr; CmdCount0 = n0; CmdCount1 = n1; CmdPad = pad; CmdValid = 1'b1;
    while (!CmdReady && n < 100) begin @(negedge Clk); n++; end
    @(negedge Clk);
    CmdValid = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input int e0, output int dcyc);
    int n;
    n = 0;
    while (!Done && n < 300) begin @(negedge Clk); n++; end
    dcyc = cyc;
    chk({tag, "_done_seen"}, Done, 1);
    chk({tag, "_latency"}, cyc - e0 + 1, exp_lat);
  endtask

  initial begin
    int e0, e0b, dc, da, s_en0, s_slt, s_clr, s_busy, s_done, b0, b1;
    Reset = 1'b1; CmdValid = 1'b0; CmdClear = 1'b0; Hold = 1'b0;
    CmdCount0 = '0; CmdCount1 = '0; CmdPad = '0;
    repeat (3) @(negedge Clk);
    chk("rst_ready", CmdReady, 1);
    chk("rst_en", En, 0);
    chk("rst_slt", Slt, 0);
    chk("rst_cntreset", CntReset, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_phase", Phase, 0);
    Reset = 1'b0;
    @(negedge Clk);

    // Clear + N0=3, N1=2: 1 + 3 + 8 + 1 = 13
    s_en0 = en0_tot; s_slt = slt_tot; s_clr = clr_tot;
    send(1'b1, 16'd3, 16'd2, 2'd0, e0);
    chk("t1_cntreset_first", CntReset, 1);
    wait_done("t1", 13, e0, dc);
    chk("t1_busy_in_done", Busy, 0);
    chk("t1_en0_pulses", en0_tot - s_en0, 3);
    chk("t1_slt_pulses", slt_tot - s_slt, 8);
    chk("t1_clr_pulses", clr_tot - s_clr, 1);
    chk("t1_out0", out0, 3);
    chk("t1_out1", out1, 2);
    chk("t1_phase", Phase, 0);

    // Pad only, then a single N1=1 needs just one Slt pulse
    s_slt = slt_tot;
    send(1'b0, 16'd0, 16'd0, 2'd3, e0);
    wait_done("t2a", 4, e0, dc);
    chk("t2a_slt_pulses", slt_tot - s_slt, 3);
    chk("t2a_phase", Phase, 3);
    chk("t2a_cnt_phase", cph, 3);
    chk("t2a_out1", out1, 2);
    s_slt = slt_tot;
    send(1'b0, 16'd0, 16'd1, 2'd0, e0);
    wait_done("t2b", 2, e0, dc);
    chk("t2b_slt_pulses", slt_tot - s_slt, 1);
    chk("t2b_out1", out1, 3);
    chk("t2b_phase", Phase, 0);

    // N0=5 with Hold high for two cycles mid-run
    s_en0 = en0_tot;
    send(1'b0, 16'd5, 16'd0, 2'd0, e0);
    @(negedge Clk);
    Hold = 1'b1;
    @(negedge Clk);
    chk("t3_held_en", En, 0);
    @(negedge Clk);
    Hold = 1'b0;
    chk("t3_held_en2", En, 0);
    wait_done("t3", 8, e0, dc);
    chk("t3_en0_pulses", en0_tot - s_en0, 5);
    chk("t3_out0", out0, 8);
    chk("t3_phase", Phase, 0);

    // Zero command
    s_en0 = en0_tot; s_slt = slt_tot; s_busy = busy_tot;
    send(1'b0, 16'd0, 16'd0, 2'd0, e0);
    wait_done("t4", 1, e0, dc);
    @(negedge Clk);
    chk("t4_en_pulses", (en0_tot - s_en0) + (slt_tot - s_slt), 0);
    chk("t4_busy_cycles", busy_tot - s_busy, 0);

    // Reset during RUN1 of N1=3
    s_done = done_tot;
    send(1'b0, 16'd0, 16'd3, 2'd0, e0);
    repeat (5) @(negedge Clk);
    chk("t5_slt_before", Slt, 1);
    Reset = 1'b1;
    #1;
    chk("t5_async_en", En, 0);
    chk("t5_async_slt", Slt, 0);
    chk("t5_async_phase", Phase, 0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("t5_ready", CmdReady, 1);
    chk("t5_no_done", done_tot - s_done, 0);
    s_slt = slt_tot;
    send(1'b0, 16'd0, 16'd1, 2'd0, e0);
    wait_done("t5", 5, e0, dc);
    chk("t5_slt_pulses", slt_tot - s_slt, 4);
    chk("t5_out1", out1, 1);

    // Back-to-back: valid held, second command changes while busy
    b0 = out0; b1 = out1;
    CmdClear = 1'b0; CmdCount0 = 16'd2; CmdCount1 = 16'd1; CmdPad = 2'd0; CmdValid = 1'b1;
    begin
      int n;
      n = 0;
      while (!CmdReady && n < 100) begin @(negedge Clk); n++; end
    end
    @(negedge Clk);
    e0 = cyc;
    CmdCount0 = 16'd3; CmdCount1 = 16'd2; CmdPad = 2'd1;
    wait_done("t6a", 7, e0, da);
    chk("t6a_out0", out0 - b0, 2);
    chk("t6a_out1", out1 - b1, 1);
    @(negedge Clk);
    chk("t6_ready_after_done", CmdReady, 1);
    @(negedge Clk);
    e0b = cyc;
    CmdValid = 1'b0;
    chk("t6b_busy", Busy, 1);
    chk("t6b_gap", e0b - da, 2);
    wait_done("t6b", 13, e0b, dc);
    chk("t6_out0_total", out0 - b0, 5);
    chk("t6_out1_total", out1 - b1, 3);
    chk("t6_phase", Phase, 1);
    chk("t6_cnt_phase", cph, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
